slt_arbiter: RTL

//  Shares one signed less-than compare datapath among NREQ requesters.

---
 rtl/slt_arb_pkg.sv | 20 ++
 rtl/slt_arbiter_if.sv | 50 +++++
 rtl/slt_rr_pick.sv | 52 +++++
 rtl/slt_arbiter.sv | 104 ++++++++++
 4 files changed

// File: rtl/slt_arb_pkg.sv
// ----------------------------------------------------------------------------
// slt_arb_pkg
//   Shared types and helpers for the signed less-than arbiter slice.
//   MAX_NREQ  : upper bound on requester count (sizes the index type)
//   word_t    : default-width operand word
//   req_idx_t : requester index, wide enough for MAX_NREQ requesters
//   rr_next() : round-robin successor of an index, wrapping at n
// ----------------------------------------------------------------------------
package slt_arb_pkg;
  localparam int MAX_NREQ  = 8;
  localparam int DEF_WIDTH = 32;

  typedef logic [DEF_WIDTH-1:0]        word_t;
  typedef logic [$clog2(MAX_NREQ)-1:0] req_idx_t;

  function automatic req_idx_t rr_next(req_idx_t w, int n);
    if (int'(w) + 1 >= n) return '0;
    return req_idx_t'(int'(w) + 1);
  endfunction
endpackage

// File: rtl/slt_arbiter_if.sv
// ----------------------------------------------------------------------------
// slt_arbiter_if
//   Request/response bundle between NREQ compare clients and slt_arbiter.
//   req_valid/req_ready/req_left/req_right : request channel per requester
//   rsp_valid/rsp_ready/rsp_lessthan       : response channel per requester
//   grant_count                            : per-requester grant statistics,
//                                            present only with SLT_ARB_STATS_EN
//   modport slave  : arbiter side
//   modport master : requester side
// ----------------------------------------------------------------------------
interface slt_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ-1:0][WIDTH-1:0] req_left;
  logic [NREQ-1:0][WIDTH-1:0] req_right;
  logic [NREQ-1:0]            rsp_valid;
  logic [NREQ-1:0]            rsp_ready;
  logic [NREQ-1:0]            rsp_lessthan;

  // Elaboration-time sanity check on the configuration.
  if (NREQ < 2 || NREQ > 8 || CNT_W < 1) begin : g_bad_cfg
    $error("slt_arbiter_if: unsupported NREQ/CNT_W");
  end

`ifdef SLT_ARB_STATS_EN
  logic [NREQ-1:0][CNT_W-1:0] grant_count;

  modport slave (
    input  req_valid, req_left, req_right, rsp_ready,
    output req_ready, rsp_valid, rsp_lessthan, grant_count
  );
  modport master (
    output req_valid, req_left, req_right, rsp_ready,
    input  req_ready, rsp_valid, rsp_lessthan, grant_count
  );
`else
  modport slave (
    input  req_valid, req_left, req_right, rsp_ready,
    output req_ready, rsp_valid, rsp_lessthan
  );
  modport master (
    output req_valid, req_left, req_right, rsp_ready,
    input  req_ready, rsp_valid, rsp_lessthan
  );
`endif
endinterface

// File: rtl/slt_rr_pick.sv
// ----------------------------------------------------------------------------
// slt_rr_pick
//   Combinational round-robin picker: rotate the eligible mask so the pointer
//   position is bit 0, take the lowest set bit, rotate the result back.
//   i_elig : eligible requesters
//   i_ptr  : requester with highest priority this cycle (< NREQ)
//   o_gnt  : one-hot grant (zero when nothing eligible)
//   o_win  : winner index (meaningful only when o_any)
//   o_any  : some requester was granted
// ----------------------------------------------------------------------------
module slt_rr_pick
  import slt_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] i_elig,
  input  req_idx_t        i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output req_idx_t        o_win,
  output logic            o_any
);
  logic [NREQ-1:0] w_rot;
  int              w_off;
  int              w_win_i;

  always_comb begin
    w_rot   = '0;
    w_off   = 0;
    w_win_i = 0;
    o_any   = 1'b0;
    o_gnt   = '0;

    // Rotate: w_rot[k] is requester (ptr + k) mod NREQ.
    for (int k = 0; k < NREQ; k++)
      for (int j = 0; j < NREQ; j++)
        if (j == (int'(i_ptr) + k) % NREQ) w_rot[k] = i_elig[j];

    // Lowest rotated position wins; scan downward so the last hit is lowest.
    for (int k = NREQ - 1; k >= 0; k--)
      if (w_rot[k]) begin
        o_any = 1'b1;
        w_off = k;
      end

    // Unrotate back to a requester index.
    w_win_i = (int'(i_ptr) + w_off) % NREQ;
    for (int j = 0; j < NREQ; j++)
      if (o_any && j == w_win_i) o_gnt[j] = 1'b1;
  end

  assign o_win = req_idx_t'(w_win_i);
endmodule

// File: rtl/slt_arbiter.sv
// ----------------------------------------------------------------------------
// slt_arbiter
//   Shares one signed less-than compare among NREQ requesters. Round-robin
//   grant over valid/ready request channels; the result is registered one
//   cycle later on the winner's response channel and held until accepted.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : slt_arbiter_if.slave (request/response channels, stats)
//   Optional: define SLT_ARB_STATS_EN for saturating per-requester grant
//   counters on bus.grant_count.
// ----------------------------------------------------------------------------
module slt_arbiter
  import slt_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  slt_arbiter_if.slave bus
);
  if (NREQ < 2 || NREQ > MAX_NREQ || CNT_W < 1) begin : g_bad_cfg
    $error("slt_arbiter: unsupported NREQ/CNT_W");
  end

  logic [NREQ-1:0]  w_elig;
  logic [NREQ-1:0]  w_gnt;
  req_idx_t         w_win;
  logic             w_any;
  logic [WIDTH-1:0] w_left;
  logic [WIDTH-1:0] w_right;
  logic             w_lt;

  logic [NREQ-1:0]  r_rsp_valid;
  logic [NREQ-1:0]  r_rsp_lt;
  req_idx_t         r_ptr;

  // A requester may be granted if its response slot is free or is being
  // drained this cycle, which allows one result per cycle back-to-back.
  assign w_elig = bus.req_valid & (~r_rsp_valid | bus.rsp_ready);

  slt_rr_pick #(.NREQ(NREQ)) u_pick (
    .i_elig (w_elig),
    .i_ptr  (r_ptr),
    .o_gnt  (w_gnt),
    .o_win  (w_win),
    .o_any  (w_any)
  );

  assign bus.req_ready = reset ? '0 : w_gnt;

  // One-hot AND-OR operand mux.
  always_comb begin
    w_left  = '0;
    w_right = '0;
    for (int i = 0; i < NREQ; i++)
      if (w_gnt[i]) begin
        w_left  = w_left  | bus.req_left[i];
        w_right = w_right | bus.req_right[i];
      end
  end

  // Signs differ: the negative one is smaller. Same sign: an unsigned compare
  // of the full words orders two's-complement values correctly.
  assign w_lt = (w_left[WIDTH-1] != w_right[WIDTH-1]) ? w_left[WIDTH-1]
                                                      : (w_left < w_right);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_valid <= '0;
      r_rsp_lt    <= '0;
      r_ptr       <= '0;
    end else begin
      if (w_any) r_ptr <= rr_next(w_win, NREQ);
      for (int i = 0; i < NREQ; i++) begin
        if (w_gnt[i]) begin
          r_rsp_valid[i] <= 1'b1;
          r_rsp_lt[i]    <= w_lt;
        end else if (bus.rsp_ready[i]) begin
          r_rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_lessthan = r_rsp_lt;

`ifdef SLT_ARB_STATS_EN
  logic [NREQ-1:0][CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        if (w_gnt[i] && r_cnt[i] != {CNT_W{1'b1}}) r_cnt[i] <= r_cnt[i] + 1'b1;
    end
  end

  assign bus.grant_count = r_cnt;
`endif
endmodule
